// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
//
// Shared definitions for the PLL lock sequencer:
//   - seq_state_t : 2-bit sequencer state, encoded as it appears on state_o.
//   - DEF_*       : default timing constants for the 27 MHz board clock.
//   - cnt_w()     : width of a counter that must hold 0..n-1 (never below 1).
// -----------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_t;

    // 27 MHz board clock: 16-cycle reset pulse, 10 ms lock budget,
    // 100 us of continuous lock, 4-cycle dropout filter.
    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 270000;
    localparam int unsigned DEF_STABLE_CYCLES = 2700;
    localparam int unsigned DEF_GLITCH_CYCLES = 4;
    localparam int unsigned DEF_RETRY_W       = 8;

    // A counter running 0..n-1 needs clog2(n) bits; n=1 still needs one
    // bit so the register declaration stays legal.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Generic single-bit two-flop synchroniser. Both flops clear to 0 while
// i_rst_n is low, so a synchronised level always starts deasserted.
//
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input level
//   o_q     : i_d re-timed to i_clk, two cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Runs on the free-running 27 MHz board clock and owns the PLL reset input.
// It pulses pll_reset, waits for the (synchronised) PLL lock to stay high
// long enough, then releases the system reset. A lock that never settles
// within the attempt budget, or a lock dropout longer than the glitch
// filter while running, sends the sequence back to the PLL reset pulse and
// bumps a saturating retry counter.
//
// Ports:
//   clk        : 27 MHz free-running reference clock
//   resetn     : asynchronous active-low reset
//   pll_lock   : PLL LOCK output, asynchronous to clk
//   pll_reset  : PLL RESET input, active high (high in RST)
//   sys_resetn : system reset, active low, released only in RUN
//   locked     : high only in RUN
//   state_o    : current state (RST=0, WAIT=1, STABLE=2, RUN=3)
//   retry_cnt  : saturating count of PLL reset re-entries since reset
//
// All outputs are registered; they are loaded from the next-state decode so
// they change on the same edge as the state they describe.
// -----------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned GLITCH_CYCLES = DEF_GLITCH_CYCLES,
    parameter int unsigned RETRY_W       = DEF_RETRY_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               sys_resetn,
    output logic               locked,
    output logic [1:0]         state_o,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned RST_W = cnt_w(RST_CYCLES);
    localparam int unsigned TMO_W = cnt_w(LOCK_TIMEOUT);
    localparam int unsigned STB_W = cnt_w(STABLE_CYCLES);
    localparam int unsigned GLT_W = cnt_w(GLITCH_CYCLES);

    // Terminal values: each counter stops here and is cleared on the
    // transition it triggers, so it never increments past its last value.
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [GLT_W-1:0] GLT_LAST = GLT_W'(GLITCH_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

    logic               w_lock_s;

    seq_state_t         r_state;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [TMO_W-1:0]   r_att_cnt;
    logic [STB_W-1:0]   r_stab_cnt;
    logic [GLT_W-1:0]   r_drop_cnt;
    logic [RETRY_W-1:0] r_retry;
    logic               r_pll_reset;
    logic               r_sys_resetn;
    logic               r_locked;

    seq_state_t         w_state_nxt;
    logic [RST_W-1:0]   w_rst_cnt_nxt;
    logic [TMO_W-1:0]   w_att_cnt_nxt;
    logic [STB_W-1:0]   w_stab_cnt_nxt;
    logic [GLT_W-1:0]   w_drop_cnt_nxt;
    logic               w_retry_inc;
    logic [RETRY_W-1:0] w_retry_nxt;

    sync_2ff u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_d     (pll_lock),
        .o_q     (w_lock_s)
    );

    // State and counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_RST;
            r_rst_cnt    <= '0;
            r_att_cnt    <= '0;
            r_stab_cnt   <= '0;
            r_drop_cnt   <= '0;
            r_retry      <= '0;
            r_pll_reset  <= 1'b1;
            r_sys_resetn <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_att_cnt    <= w_att_cnt_nxt;
            r_stab_cnt   <= w_stab_cnt_nxt;
            r_drop_cnt   <= w_drop_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_pll_reset  <= (w_state_nxt == ST_RST);
            r_sys_resetn <= (w_state_nxt == ST_RUN);
            r_locked     <= (w_state_nxt == ST_RUN);
        end
    end

    // Next-state and counter decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_rst_cnt_nxt  = r_rst_cnt;
        w_att_cnt_nxt  = r_att_cnt;
        w_stab_cnt_nxt = r_stab_cnt;
        w_drop_cnt_nxt = r_drop_cnt;
        w_retry_inc    = 1'b0;

        case (r_state)
            ST_RST: begin
                // Lock is deliberately ignored while the PLL is held in reset.
                if (r_rst_cnt == RST_LAST) begin
                    w_state_nxt   = ST_WAIT;
                    w_rst_cnt_nxt = '0;
                    w_att_cnt_nxt = '0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                end
            end

            ST_WAIT, ST_STABLE: begin
                // The attempt budget spans WAIT and STABLE together and wins
                // over any lock-driven transition in the same cycle.
                if (r_att_cnt == TMO_LAST) begin
                    w_state_nxt    = ST_RST;
                    w_att_cnt_nxt  = '0;
                    w_stab_cnt_nxt = '0;
                    w_retry_inc    = 1'b1;
                end else begin
                    w_att_cnt_nxt = r_att_cnt + 1'b1;
                    if (r_state == ST_WAIT) begin
                        if (w_lock_s) begin
                            w_state_nxt    = ST_STABLE;
                            w_stab_cnt_nxt = '0;
                        end
                    end else if (!w_lock_s) begin
                        // Fall back to WAIT but keep the attempt timer running
                        // so a chattering lock still times out.
                        w_state_nxt    = ST_WAIT;
                        w_stab_cnt_nxt = '0;
                    end else if (r_stab_cnt == STB_LAST) begin
                        w_state_nxt    = ST_RUN;
                        w_stab_cnt_nxt = '0;
                    end else begin
                        w_stab_cnt_nxt = r_stab_cnt + 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // Only an unbroken run of GLITCH_CYCLES low samples counts
                // as lock loss; any high sample restarts the filter.
                if (w_lock_s) begin
                    w_drop_cnt_nxt = '0;
                end else if (r_drop_cnt == GLT_LAST) begin
                    w_state_nxt    = ST_RST;
                    w_drop_cnt_nxt = '0;
                    w_retry_inc    = 1'b1;
                end else begin
                    w_drop_cnt_nxt = r_drop_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    // Retry counter holds at all-ones instead of wrapping back to zero.
    always_comb begin
        w_retry_nxt = r_retry;
        if (w_retry_inc && (r_retry != RETRY_MAX)) begin
            w_retry_nxt = r_retry + 1'b1;
        end
    end

    assign pll_reset  = r_pll_reset;
    assign sys_resetn = r_sys_resetn;
    assign locked     = r_locked;
    assign state_o    = r_state;
    assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Two sequencers share every input: one with an 8-bit retry counter and one
// with a 2-bit retry counter. A behavioural model of the sequencing rules is
// stepped on every clock and compared against both instances on every falling
// edge; directed phases add literal expectations at chosen edges.
// Edge numbering: edge 0 is reset release, edge n is the n-th rising clock
// edge after it; values are sampled 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RC = 4;
    localparam int TO = 50;
    localparam int SC = 10;
    localparam int GC = 3;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b1;
    logic       pll_lock = 1'b0;

    logic       pll_reset, sys_resetn, locked;
    logic [1:0] state_o;
    logic [7:0] retry_cnt;
    logic       pll_reset_s, sys_resetn_s, locked_s;
    logic [1:0] state_o_s;
    logic [1:0] retry_cnt_s;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;
    int ec       = 0;

    // Behavioural model: phase 0=reset pulse, 1=waiting, 2=qualifying, 3=run.
    int m_state = 0;
    int m_rst   = 0;
    int m_att   = 0;
    int m_stab  = 0;
    int m_drop  = 0;
    int m_retry = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    pll_lock_sequencer #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC),
        .GLITCH_CYCLES(GC), .RETRY_W(8)
    ) dut (
        .clk(clk), .resetn(resetn), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .sys_resetn(sys_resetn), .locked(locked),
        .state_o(state_o), .retry_cnt(retry_cnt)
    );

    pll_lock_sequencer #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC),
        .GLITCH_CYCLES(GC), .RETRY_W(2)
    ) dut_sat (
        .clk(clk), .resetn(resetn), .pll_lock(pll_lock),
        .pll_reset(pll_reset_s), .sys_resetn(sys_resetn_s), .locked(locked_s),
        .state_o(state_o_s), .retry_cnt(retry_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_rst = 0; m_att = 0; m_stab = 0; m_drop = 0;
        m_retry = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_step();
        bit ls;
        ls   = m_s2;           // lock as seen two edges after it was sampled
        m_s2 = m_s1;
        m_s1 = pll_lock;
        if (m_state == 0) begin
            if (m_rst == RC - 1) begin
                m_state = 1; m_rst = 0; m_att = 0;
            end else begin
                m_rst++;
            end
        end else if (m_state == 3) begin
            m_drop = ls ? 0 : m_drop + 1;
            if (m_drop == GC) begin
                m_state = 0; m_drop = 0; m_retry++;
            end
        end else begin
            m_att++;
            if (m_att == TO) begin
                m_state = 0; m_att = 0; m_stab = 0; m_retry++;
            end else if (!ls) begin
                m_state = 1; m_stab = 0;
            end else if (m_state == 1) begin
                m_state = 2; m_stab = 0;
            end else begin
                m_stab++;
                if (m_stab == SC) begin
                    m_state = 3; m_stab = 0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else         model_step();
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic compare_model(input string nm);
        int e8, e2;
        bit ok;
        e8 = (m_retry > 255) ? 255 : m_retry;
        e2 = (m_retry > 3) ? 3 : m_retry;
        ok = (int'(state_o) == m_state) && (pll_reset == (m_state == 0)) &&
             (sys_resetn == (m_state == 3)) && (locked == (m_state == 3)) &&
             (int'(retry_cnt) == e8) &&
             (int'(state_o_s) == m_state) && (pll_reset_s == (m_state == 0)) &&
             (sys_resetn_s == (m_state == 3)) && (locked_s == (m_state == 3)) &&
             (int'(retry_cnt_s) == e2);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s t=%0t: got st=%0d prst=%0b srn=%0b lk=%0b rc=%0d | st_s=%0d prst_s=%0b srn_s=%0b lk_s=%0b rc_s=%0d ; expected st=%0d prst=%0b srn=%0b lk=%0b rc=%0d rc_s=%0d",
                     nm, $time, state_o, pll_reset, sys_resetn, locked, retry_cnt,
                     state_o_s, pll_reset_s, sys_resetn_s, locked_s, retry_cnt_s,
                     m_state, (m_state == 0), (m_state == 3), (m_state == 3), e8, e2);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) compare_model("model_cmp");
        end
    end

    // Assert reset between edges, release on a falling edge; edge 0 = release.
    task automatic do_reset();
        @(posedge clk);
        #3 resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        ec     = 0;
        cmp_en = 1'b1;
    endtask

    task automatic to_edge(input int k);
        while (ec < k) begin
            @(posedge clk);
            ec++;
        end
        #1;
    endtask

    initial begin
        bit seen_run;
        bit lv;
        int seg;

        // ---------------- clean lock, then RUN glitch filter ----------------
        pll_lock = 1'b0;
        do_reset();
        chk("reset_state", state_o, 0);
        chk("reset_pll_reset", pll_reset, 1);
        chk("reset_sys_resetn", sys_resetn, 0);
        chk("reset_retry", retry_cnt, 0);
        to_edge(3);
        chk("clean_prst_e3", pll_reset, 1);
        to_edge(4);
        chk("clean_prst_e4", pll_reset, 0);
        chk("clean_wait_e4", state_o, 1);
        to_edge(9);
        pll_lock = 1'b1;                    // first sampled at edge 10
        to_edge(21);
        chk("clean_srn_e21", sys_resetn, 0);
        to_edge(22);
        chk("clean_srn_e22", sys_resetn, 1);
        chk("clean_locked_e22", locked, 1);
        chk("clean_model_run", m_state, 3);
        chk("clean_retry", retry_cnt, 0);
        to_edge(30);
        pll_lock = 1'b0;                    // 2-sample dropout: edges 31,32
        to_edge(32);
        pll_lock = 1'b1;
        to_edge(40);
        chk("glitch2_state", state_o, 3);
        chk("glitch2_srn", sys_resetn, 1);
        pll_lock = 1'b0;                    // 3-sample dropout: edges 41..43
        to_edge(44);
        chk("glitch3_srn_e44", sys_resetn, 1);
        to_edge(45);
        chk("glitch3_srn_e45", sys_resetn, 0);
        chk("glitch3_locked", locked, 0);
        chk("glitch3_prst", pll_reset, 1);
        chk("glitch3_retry", retry_cnt, 1);

        // ---------------- never lock + retry saturation ----------------
        pll_lock = 1'b0;
        do_reset();
        to_edge(53);
        chk("nolock_retry_e53", retry_cnt, 0);
        chk("nolock_state_e53", state_o, 1);
        to_edge(54);
        chk("nolock_retry_e54", retry_cnt, 1);
        chk("nolock_prst_e54", pll_reset, 1);
        chk("model_retry_e54", m_retry, 1);
        to_edge(58);
        chk("nolock_prst_e58", pll_reset, 0);
        to_edge(108);
        chk("nolock_retry_e108", retry_cnt, 2);
        to_edge(162);
        chk("nolock_retry_e162", retry_cnt, 3);
        chk("nolock_srn_e162", sys_resetn, 0);
        to_edge(216);
        chk("sat_retry_e216", retry_cnt_s, 3);
        to_edge(270);
        chk("nolock_retry_e270", retry_cnt, 5);
        chk("sat_retry_e270", retry_cnt_s, 3);

        // ---------------- chatter in STABLE ----------------
        pll_lock = 1'b0;
        do_reset();
        seen_run = 1'b0;
        for (int e = 1; e <= 54; e++) begin
            to_edge(e);
            if (sys_resetn) seen_run = 1'b1;
            pll_lock = ((e % 6) != 5);      // 5 high samples, 1 low
        end
        chk("chatter_no_run", seen_run, 0);
        chk("chatter_retry", retry_cnt, 1);
        chk("chatter_state", state_o, 0);

        // ---------------- async reset mid-STABLE ----------------
        pll_lock = 1'b0;
        do_reset();
        to_edge(54);
        chk("async_pre_retry", retry_cnt, 1);
        to_edge(59);
        pll_lock = 1'b1;                    // first sampled at edge 60
        to_edge(64);
        chk("async_pre_stable", state_o, 2);
        #2 resetn = 1'b0;
        #1;
        chk("async_state", state_o, 0);
        chk("async_prst", pll_reset, 1);
        chk("async_srn", sys_resetn, 0);
        chk("async_locked", locked, 0);
        chk("async_retry", retry_cnt, 0);
        chk("async_retry_s", retry_cnt_s, 0);
        @(negedge clk);
        resetn = 1'b1;
        ec = 0;
        to_edge(3);
        chk("async_restart_e3", state_o, 0);
        to_edge(4);
        chk("async_restart_e4", state_o, 1);
        to_edge(5);
        chk("async_restart_e5", state_o, 2);

        // ---------------- randomized lock behaviour ----------------
        do_reset();
        seg = 0;
        lv  = 1'b0;
        for (int e = 1; e <= 4000; e++) begin
            to_edge(e);
            if (seg == 0) begin
                lv  = ($urandom_range(0, 3) != 0);
                seg = lv ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 5));
            end
            pll_lock = lv;
            seg--;
            if ($urandom_range(0, 799) == 0) begin
                #2 resetn = 1'b0;
                #4 resetn = 1'b1;
            end
        end

        to_edge(4005);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
